// File: rtl/plru_tree.sv
// Tree pseudo-LRU replacement state for an N-way set-associative cache.
// One (NUM_WAYS-1)-bit heap-indexed tree per set; registered victim choice.
module plru_tree #(
   parameter  int S_INDEX  = 4,
   parameter  int NUM_WAYS = 4,
   localparam int W_WAY    = $clog2(NUM_WAYS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                touch_valid,
   input  logic [S_INDEX-1:0]  touch_set,
   input  logic [W_WAY-1:0]    touch_way,
   input  logic                victim_req,
   input  logic [S_INDEX-1:0]  victim_set,
   input  logic [NUM_WAYS-1:0] valid_i,
   input  logic [NUM_WAYS-1:0] lock_i,
   input  logic                flush,
   output logic                ready,
   output logic                victim_valid,
   output logic [W_WAY-1:0]    victim_way,
   output logic [NUM_WAYS-1:0] victim_onehot,
   output logic                victim_none
);

   localparam int NUM_SETS = 2 ** S_INDEX;
   localparam logic [S_INDEX-1:0] CNT_LAST = S_INDEX'(NUM_SETS - 1);

   // Handshake: touch_valid and victim_req are accepted only in a cycle where
   // ready=1; a result appears as a one-cycle victim_valid pulse the cycle after.
   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FLUSH} state_t;

   state_t                r_state, w_state_nxt;
   logic [S_INDEX-1:0]    r_cnt, w_cnt_nxt;
   logic [NUM_WAYS-1:0]   r_tree [NUM_SETS];   // bit 0 unused; nodes 1..NUM_WAYS-1
   logic [NUM_WAYS-1:0]   w_touch_bits;
   logic                  w_touch_en;
   logic [NUM_WAYS-1:0]   w_rd;
   logic [NUM_WAYS-1:0]   w_free;
   logic [W_WAY-1:0]      w_sel_way;
   logic                  w_sel_none;
   logic [NUM_WAYS-1:0]   w_sel_onehot;
   logic                  r_victim_valid;
   logic [W_WAY-1:0]      r_victim_way;
   logic [NUM_WAYS-1:0]   r_victim_onehot;
   logic                  r_victim_none;

   assign ready      = (r_state == ST_IDLE);
   assign w_touch_en = ready && touch_valid && !flush;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (flush) begin
               w_state_nxt = ST_FLUSH;
               w_cnt_nxt   = '0;
            end
         end
         ST_INIT, ST_FLUSH: begin
            if (flush) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Each node on the touched path is pointed at the sibling of the path.
   always_comb begin
      logic [W_WAY:0] node;
      logic           dir;
      w_touch_bits = r_tree[touch_set];
      node         = (W_WAY + 1)'(1);
      for (int l = 0; l < W_WAY; l++) begin
         dir                             = touch_way[W_WAY-1-l];
         w_touch_bits[node[W_WAY-1:0]]   = ~dir;
         node                            = {node[W_WAY-1:0], dir};
      end
   end

   // Tree storage has no reset; the INIT sweep defines it before first use.
   always_ff @(posedge clk) begin
      if (!ready) begin
         r_tree[r_cnt] <= '0;
      end else if (w_touch_en) begin
         r_tree[touch_set] <= w_touch_bits;
      end
   end

   always_comb begin
      logic [W_WAY:0]      node;
      logic                dir;
      int                  lo;
      int                  half;
      logic [NUM_WAYS-1:0] in_l;
      logic [NUM_WAYS-1:0] in_r;
      w_rd       = r_tree[victim_set];
      w_free     = ~valid_i & ~lock_i;
      w_sel_way  = '0;
      w_sel_none = 1'b0;
      node       = (W_WAY + 1)'(1);
      dir        = 1'b0;
      lo         = 0;
      half       = NUM_WAYS;
      in_l       = '0;
      in_r       = '0;
      if (&lock_i) begin
         w_sel_none = 1'b1;
      end else if (|w_free) begin
         for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (w_free[w]) w_sel_way = W_WAY'(w);
         end
      end else begin
         // A locked-out preferred subtree diverts the walk to its sibling.
         for (int l = 0; l < W_WAY; l++) begin
            half = half / 2;
            for (int w = 0; w < NUM_WAYS; w++) begin
               in_l[w] = (w >= lo) && (w < lo + half);
               in_r[w] = (w >= lo + half) && (w < lo + 2 * half);
            end
            dir = w_rd[node[W_WAY-1:0]];
            if (!dir && (&(lock_i | ~in_l))) begin
               dir = 1'b1;
            end else if (dir && (&(lock_i | ~in_r))) begin
               dir = 1'b0;
            end
            if (dir) lo = lo + half;
            node = {node[W_WAY-1:0], dir};
         end
         w_sel_way = W_WAY'(lo);
      end
      w_sel_onehot = w_sel_none ? '0 : (NUM_WAYS'(1) << w_sel_way);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_victim_valid  <= 1'b0;
         r_victim_way    <= '0;
         r_victim_onehot <= '0;
         r_victim_none   <= 1'b0;
      end else begin
         r_victim_valid <= ready && victim_req;
         if (ready && victim_req) begin
            r_victim_way    <= w_sel_way;
            r_victim_onehot <= w_sel_onehot;
            r_victim_none   <= w_sel_none;
         end
      end
   end

   assign victim_valid  = r_victim_valid;
   assign victim_way    = r_victim_way;
   assign victim_onehot = r_victim_onehot;
   assign victim_none   = r_victim_none;

endmodule

// File: doc/plru_tree.md
Name: plru_tree

Overview:
Parametrised tree pseudo-LRU replacement unit for the N-way set-associative cache. It holds one (NUM_WAYS-1)-bit PLRU tree per set, updated on hit/fill touches. It answers victim requests with a registered way choice that prefers invalid ways, honours a per-way lock mask, and supports a multi-cycle flush sweep. It sits between the cache controller FSM and the tag/valid arrays, replacing the fixed 4-way unit.

Parameters:
S_INDEX, 4, set index width; number of sets NUM_SETS = 2**S_INDEX.
NUM_WAYS, 4, associativity; power of two, 2..16.
W_WAY, $clog2(NUM_WAYS), way number width (derived; not overridable).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
touch_valid  in  1  apply a touch this cycle.
touch_set  in  S_INDEX  set touched.
touch_way  in  W_WAY  way hit or filled.
victim_req  in  1  request victim for victim_set; single-cycle pulse.
victim_set  in  S_INDEX  set being queried.
valid_i  in  NUM_WAYS  valid bits of victim_set, sampled with victim_req.
lock_i  in  NUM_WAYS  per-way lock; locked ways are never chosen.
flush  in  1  pulse; clear all trees.
ready  out  1  1 when idle and accepting touch/victim_req.
victim_valid  out  1  one-cycle pulse; victim result valid.
victim_way  out  W_WAY  chosen way.
victim_onehot  out  NUM_WAYS  one-hot of victim_way; all zero when victim_none.
victim_none  out  1  all ways locked; no victim.

Behaviour:
- Tree encoding: heap-indexed nodes 1..NUM_WAYS-1; children of node n are 2n (left, lower ways) and 2n+1. Bit 0 means the victim walk goes left.
- Touch: every node on the path to touch_way is set to point away from it (left child on path -> bit 1, right -> bit 0). Other nodes are unchanged. The update is visible the cycle after the touch.
- Victim selection is combinational from stored state plus valid_i/lock_i, and registered: victim_req in cycle T gives victim_valid=1 in T+1, with outputs held until the next result.
  1. If any way is ~valid_i & ~lock_i, choose the lowest-index such way.
  2. Otherwise walk from the root and follow each node bit. If every way in the chosen subtree is locked, take the sibling subtree.
  3. If all ways are locked, set victim_none=1, victim_onehot=0, victim_way=0.
- Victim selection never modifies the tree. The controller issues a touch on the fill.
- Same-cycle touch and victim_req to the same set: the victim uses the pre-touch state, and the touch is still applied.
- FSM states: INIT, IDLE, FLUSH.
  - Reset enters INIT.
  - INIT and FLUSH run a set counter from 0 to NUM_SETS-1, zeroing one tree per cycle, then go to IDLE. The sweep takes NUM_SETS cycles.
  - ready=1 only in IDLE. touch_valid and victim_req are ignored when ready=0.
  - flush in IDLE moves to FLUSH next cycle and has priority over a same-cycle touch, which is dropped. A same-cycle victim_req is still answered.
  - flush during INIT or FLUSH restarts the counter at 0.
- Reset values: ready=0, victim_valid=0, victim_way=0, victim_onehot=0, victim_none=0, counter=0. Tree contents are undefined until the sweep completes.
- rst_n asserted mid-sweep or mid-request returns to INIT immediately, and a pending victim_valid is cancelled.
- Out-of-range touch_way cannot occur, since NUM_WAYS is a power of two.

Test Plan:
- Reset, NUM_SETS=16 -> ready=0 for 16 cycles, then 1; victim_req set 2 with valid_i=4'b1111, lock_i=0 -> next cycle victim_way=0, onehot=4'b0001.
- Touch set 2 way 0, then victim_req with all ways valid -> victim_way=2. Touch way 2, then victim_req -> victim_way=1.
- valid_i=4'b1011, lock_i=0 -> victim_way=2 regardless of tree. valid_i=4'b1011, lock_i=4'b0100 -> victim from tree walk, never 2.
- Fresh tree, lock_i=4'b0011 -> walk forced right, victim_way=2. lock_i=4'b1111 -> victim_none=1, onehot=0.
- Touch set 5 way 3 and victim_req set 5 in the same cycle on a fresh tree -> victim_way=0; next request -> victim_way=0 (node1=0, node2=0).
- Touch several sets, pulse flush -> ready low for 16 cycles; every set then returns victim_way=0. Repeat with a second flush mid-sweep -> the sweep restarts (total low time = restart point + 16).
